// File: rtl/snitch_shared_acc_arbiter.sv
// Shares one offloaded accelerator among NrCores core request ports; responses return in request order.
// Latency: 0 cycles combinational for both the request and response paths (no data-path registers).
// Backpressure: a stalled grant is locked until it transfers; the tracking FIFO being full blocks new grants.
//
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   core_req_i/_valid_i/_ready_o          per-core request channel (valid/ready)
//   core_resp_o/_valid_o/_ready_i         per-core response channel (payload broadcast, valid routed)
//   acc_req_o/_valid_o/_ready_i           request channel to the shared unit
//   acc_resp_i/_valid_i/_ready_o          in-order response channel from the shared unit
//   outstanding_o                         tracking FIFO occupancy
//   busy_o                                requests in flight or a request being offered
module snitch_shared_acc_arbiter #(
  parameter int unsigned NrCores        = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ReqWidth       = 32,
  parameter int unsigned RespWidth      = 32,
  parameter int unsigned IdxWidth       = (NrCores > 1) ? $clog2(NrCores) : 1,
  parameter int unsigned CntWidth       = (MaxOutstanding + 1 > 1) ? $clog2(MaxOutstanding + 1) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrCores-1:0][ReqWidth-1:0]   core_req_i,
  input  logic [NrCores-1:0]                 core_req_valid_i,
  output logic [NrCores-1:0]                 core_req_ready_o,
  output logic [NrCores-1:0][RespWidth-1:0]  core_resp_o,
  output logic [NrCores-1:0]                 core_resp_valid_o,
  input  logic [NrCores-1:0]                 core_resp_ready_i,
  output logic [ReqWidth-1:0]                acc_req_o,
  output logic                               acc_req_valid_o,
  input  logic                               acc_req_ready_i,
  input  logic [RespWidth-1:0]               acc_resp_i,
  input  logic                               acc_resp_valid_i,
  output logic                               acc_resp_ready_o,
  output logic [CntWidth-1:0]                outstanding_o,
  output logic                               busy_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef logic [IdxWidth-1:0] idx_t;
  typedef logic [IdxWidth:0]   cand_t;
  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  localparam cand_t NrCoresC = cand_t'(NrCores);
  localparam idx_t  LastCore = idx_t'(NrCores - 1);
  localparam ptr_t  LastSlot = ptr_t'(MaxOutstanding - 1);
  localparam cnt_t  MaxCnt   = cnt_t'(MaxOutstanding);

  typedef enum logic {ArbIdle, ArbLocked} arb_state_e;

  arb_state_e         state;
  idx_t               rr_ptr;
  idx_t               lock_idx;
  idx_t               grant_idx;
  idx_t               next_rr;
  idx_t               head_idx;
  idx_t               fifo_mem [MaxOutstanding];
  ptr_t               wr_ptr;
  ptr_t               rd_ptr;
  cnt_t               count;
  cand_t              cand;
  logic               full;
  logic               empty;
  logic               found;
  logic               req_valid;
  logic               resp_ok;
  logic               push;
  logic               pop;
  logic [NrCores-1:0] eligible;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastSlot) ? '0 : p + ptr_t'(1);
  endfunction

  assign full     = (count == MaxCnt);
  assign empty    = (count == '0);
  // A full FIFO masks every requester, so a pop in the same cycle cannot admit a grant.
  assign eligible = core_req_valid_i & {NrCores{~full}};

  // Round-robin search starting at rr_ptr; a locked grant overrides the search.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_ptr;
    cand      = '0;
    if (state == ArbLocked) begin
      found     = 1'b1;
      grant_idx = lock_idx;
    end else begin
      for (int unsigned i = 0; i < NrCores; i++) begin
        cand = cand_t'(rr_ptr) + cand_t'(i);
        if (cand >= NrCoresC) cand = cand - NrCoresC;
        if (!found && eligible[idx_t'(cand)]) begin
          found     = 1'b1;
          grant_idx = idx_t'(cand);
        end
      end
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks out before state settles.
  assign req_valid       = rst_ni & found;
  assign acc_req_valid_o = req_valid;
  assign acc_req_o       = core_req_i[grant_idx];
  assign push            = req_valid & acc_req_ready_i;
  assign next_rr         = (grant_idx == LastCore) ? '0 : grant_idx + idx_t'(1);

  always_comb begin
    core_req_ready_o = '0;
    if (req_valid) core_req_ready_o[grant_idx] = acc_req_ready_i;
  end

  // Response routing follows the oldest tracked issuer.
  assign head_idx         = fifo_mem[rd_ptr];
  assign resp_ok          = rst_ni & ~empty;
  assign acc_resp_ready_o = resp_ok & core_resp_ready_i[head_idx];
  assign pop              = acc_resp_valid_i & acc_resp_ready_o;
  assign core_resp_o      = {NrCores{acc_resp_i}};

  always_comb begin
    core_resp_valid_o = '0;
    if (resp_ok) core_resp_valid_o[head_idx] = acc_resp_valid_i;
  end

  assign outstanding_o = count;
  assign busy_o        = (count != '0) | req_valid;

  // Lock FSM: a grant offered but not accepted is held until it transfers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ArbIdle;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      case (state)
        ArbIdle: begin
          if (push) begin
            rr_ptr <= next_rr;
          end else if (req_valid) begin
            state    <= ArbLocked;
            lock_idx <= grant_idx;
          end
        end
        ArbLocked: begin
          if (push) begin
            state  <= ArbIdle;
            rr_ptr <= next_rr;
          end
        end
        default: state <= ArbIdle;
      endcase
    end
  end

  // Tracking FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= grant_idx;
  end

  a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state == ArbLocked) |-> $stable(acc_req_o));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !full);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> !empty);
  a_resp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    acc_resp_valid_i |-> !empty);
  a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(core_req_ready_o));

endmodule

// File: tb/tb_snitch_shared_acc_arbiter.sv
module tb_snitch_shared_acc_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0][31:0] core_req;
  logic [3:0]       core_req_valid;
  logic [3:0]       core_req_ready;
  logic [3:0][31:0] core_resp;
  logic [3:0]       core_resp_valid;
  logic [3:0]       core_resp_ready;
  logic [31:0]      acc_req;
  logic             acc_req_valid;
  logic             acc_req_ready;
  logic [31:0]      acc_resp;
  logic             acc_resp_valid;
  logic             acc_resp_ready;
  logic [2:0]       outstanding;
  logic             busy;

  snitch_shared_acc_arbiter #(
    .NrCores(4), .MaxOutstanding(4), .ReqWidth(32), .RespWidth(32)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .core_req_i        (core_req),
    .core_req_valid_i  (core_req_valid),
    .core_req_ready_o  (core_req_ready),
    .core_resp_o       (core_resp),
    .core_resp_valid_o (core_resp_valid),
    .core_resp_ready_i (core_resp_ready),
    .acc_req_o         (acc_req),
    .acc_req_valid_o   (acc_req_valid),
    .acc_req_ready_i   (acc_req_ready),
    .acc_resp_i        (acc_resp),
    .acc_resp_valid_i  (acc_resp_valid),
    .acc_resp_ready_o  (acc_resp_ready),
    .outstanding_o     (outstanding),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  req_vld;
    logic        req_rdy;
    logic        resp_vld;
    logic [3:0]  resp_rdy;
    logic [31:0] resp_dat;
    logic        exp_req_vld;
    int          exp_grant;
    logic [3:0]  exp_resp_vld;
    logic        exp_resp_rdy;
    int          exp_out;
  } vec_t;

  vec_t tbl[$];
  int   exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] payload(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  function automatic vec_t mk(input string nm, input logic [3:0] rv, input logic rr,
                              input logic sv, input logic [3:0] sr, input logic [31:0] d,
                              input logic ev, input int eg, input logic [3:0] erv,
                              input logic err, input int eo);
    vec_t v;
    v.nm = nm; v.req_vld = rv; v.req_rdy = rr; v.resp_vld = sv; v.resp_rdy = sr;
    v.resp_dat = d; v.exp_req_vld = ev; v.exp_grant = eg; v.exp_resp_vld = erv;
    v.exp_resp_rdy = err; v.exp_out = eo;
    return v;
  endfunction

  task automatic check(input string nm, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, want %0h", nm, field, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, compare outputs mid-cycle, and run the issue-order scoreboard.
  task automatic apply(input vec_t v);
    logic [3:0] exp_rdy;
    int         exp_core;
    @(posedge clk);
    #1;
    core_req_valid  = v.req_vld;
    acc_req_ready   = v.req_rdy;
    acc_resp_valid  = v.resp_vld;
    core_resp_ready = v.resp_rdy;
    acc_resp        = v.resp_dat;
    @(negedge clk);
    exp_rdy = (v.exp_req_vld && v.req_rdy) ? (4'b0001 << v.exp_grant) : 4'b0000;
    check(v.nm, "acc_req_valid",   64'(acc_req_valid),   64'(v.exp_req_vld));
    check(v.nm, "core_req_ready",  64'(core_req_ready),  64'(exp_rdy));
    if (v.exp_req_vld) check(v.nm, "acc_req", 64'(acc_req), 64'(payload(v.exp_grant)));
    check(v.nm, "core_resp_valid", 64'(core_resp_valid), 64'(v.exp_resp_vld));
    check(v.nm, "acc_resp_ready",  64'(acc_resp_ready),  64'(v.exp_resp_rdy));
    check(v.nm, "outstanding",     64'(outstanding),     64'(v.exp_out));
    check(v.nm, "busy",            64'(busy),            64'((v.exp_out != 0) || v.exp_req_vld));
    if (v.resp_vld && v.exp_resp_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s.sb_underflow: got response delivery, want none tracked", v.nm);
      end else begin
        exp_core = exp_q.pop_front();
        check(v.nm, "resp_route", 64'(core_resp_valid), 64'(4'b0001 << exp_core));
        check(v.nm, "resp_dat",   64'(core_resp[exp_core]), 64'(v.resp_dat));
      end
    end
    if (v.exp_req_vld && v.req_rdy) exp_q.push_back(v.exp_grant);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) core_req[i] = payload(i);
    core_req_valid  = '0;
    acc_req_ready   = 1'b0;
    acc_resp_valid  = 1'b0;
    core_resp_ready = '0;
    acc_resp        = '0;
    rst_n           = 1'b0;

    //           name        reqv    rdy   rspv  rsprdy   data          ev  g   exp_rspv exp_rr out
    tbl.push_back(mk("rst_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b0, -1, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("single",   4'b0100, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  2, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("resp2",    4'b0000, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, -1, 4'b0100, 1'b1, 1));
    tbl.push_back(mk("drained",  4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b0, -1, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("rr_align", 4'b1000, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  3, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("rr0",      4'b1111, 1'b1, 1'b1, 4'b1111, 32'h5A5A_0001, 1'b1,  0, 4'b1000, 1'b1, 1));
    tbl.push_back(mk("rr1",      4'b1111, 1'b1, 1'b1, 4'b1111, 32'h5A5A_0002, 1'b1,  1, 4'b0001, 1'b1, 1));
    tbl.push_back(mk("rr2",      4'b1111, 1'b1, 1'b1, 4'b1111, 32'h5A5A_0003, 1'b1,  2, 4'b0010, 1'b1, 1));
    tbl.push_back(mk("rr3",      4'b1111, 1'b1, 1'b1, 4'b1111, 32'h5A5A_0004, 1'b1,  3, 4'b0100, 1'b1, 1));
    tbl.push_back(mk("rr4",      4'b1111, 1'b1, 1'b1, 4'b1111, 32'h5A5A_0005, 1'b1,  0, 4'b1000, 1'b1, 1));
    tbl.push_back(mk("rr5",      4'b1111, 1'b1, 1'b1, 4'b1111, 32'h5A5A_0006, 1'b1,  1, 4'b0001, 1'b1, 1));
    tbl.push_back(mk("rr_drain", 4'b0000, 1'b0, 1'b1, 4'b1111, 32'h5A5A_0007, 1'b0, -1, 4'b0010, 1'b1, 1));
    tbl.push_back(mk("lk_align", 4'b0001, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  0, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("lock_a",   4'b1010, 1'b0, 1'b1, 4'b1111, 32'h5A5A_0008, 1'b1,  1, 4'b0001, 1'b1, 1));
    tbl.push_back(mk("lock_b",   4'b1010, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b1,  1, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("lock_c",   4'b1010, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b1,  1, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("lock_go",  4'b1010, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  1, 4'b0000, 1'b0, 0));
    tbl.push_back(mk("lock_nxt", 4'b1000, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  3, 4'b0000, 1'b0, 1));
    tbl.push_back(mk("fill3",    4'b0001, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  0, 4'b0000, 1'b0, 2));
    tbl.push_back(mk("fill4",    4'b0010, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  1, 4'b0000, 1'b0, 3));
    tbl.push_back(mk("full",     4'b0100, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, -1, 4'b0000, 1'b0, 4));
    tbl.push_back(mk("full_pop", 4'b0100, 1'b1, 1'b1, 4'b1111, 32'h5A5A_0009, 1'b0, -1, 4'b0010, 1'b1, 4));
    tbl.push_back(mk("refill",   4'b0100, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  2, 4'b0000, 1'b0, 3));
    tbl.push_back(mk("dr_a",     4'b0000, 1'b0, 1'b1, 4'b1111, 32'h5A5A_000A, 1'b0, -1, 4'b1000, 1'b1, 4));
    tbl.push_back(mk("dr_b",     4'b0000, 1'b0, 1'b1, 4'b1111, 32'h5A5A_000B, 1'b0, -1, 4'b0001, 1'b1, 3));
    tbl.push_back(mk("dr_c",     4'b0000, 1'b0, 1'b1, 4'b1111, 32'h5A5A_000C, 1'b0, -1, 4'b0010, 1'b1, 2));
    tbl.push_back(mk("dr_d",     4'b0000, 1'b0, 1'b1, 4'b1111, 32'h5A5A_000D, 1'b0, -1, 4'b0100, 1'b1, 1));
    tbl.push_back(mk("dr_idle",  4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b0, -1, 4'b0000, 1'b0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Head-of-line stall: FIFO order {0,2}, core 0 not ready for two cycles.
    apply(mk("st_i0",  4'b0001, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  0, 4'b0000, 1'b0, 0));
    apply(mk("st_i2",  4'b0100, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1,  2, 4'b0000, 1'b0, 1));
    apply(mk("st_w1",  4'b0000, 1'b0, 1'b1, 4'b1110, 32'h0000_00A0, 1'b0, -1, 4'b0001, 1'b0, 2));
    apply(mk("st_w2",  4'b0000, 1'b0, 1'b1, 4'b1110, 32'h0000_00A0, 1'b0, -1, 4'b0001, 1'b0, 2));
    apply(mk("st_r0",  4'b0000, 1'b0, 1'b1, 4'b1111, 32'h0000_00A0, 1'b0, -1, 4'b0001, 1'b1, 2));
    apply(mk("st_r2",  4'b0000, 1'b0, 1'b1, 4'b1111, 32'h0000_00A2, 1'b0, -1, 4'b0100, 1'b1, 1));
    apply(mk("st_end", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b0, -1, 4'b0000, 1'b0, 0));

    // Asynchronous reset with three requests outstanding.
    apply(mk("ar_i0",  4'b0111, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 0, 4'b0000, 1'b0, 0));
    apply(mk("ar_i1",  4'b0111, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 1, 4'b0000, 1'b0, 1));
    apply(mk("ar_i2",  4'b0111, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 2, 4'b0000, 1'b0, 2));
    @(posedge clk);
    #1;
    core_req_valid  = 4'b1111;
    acc_req_ready   = 1'b1;
    acc_resp_valid  = 1'b1;
    core_resp_ready = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst", "acc_req_valid",   64'(acc_req_valid),   64'(0));
    check("arst", "core_req_ready",  64'(core_req_ready),  64'(0));
    check("arst", "core_resp_valid", 64'(core_resp_valid), 64'(0));
    check("arst", "acc_resp_ready",  64'(acc_resp_ready),  64'(0));
    check("arst", "outstanding",     64'(outstanding),     64'(0));
    check("arst", "busy",            64'(busy),            64'(0));
    acc_resp_valid = 1'b0;
    core_req_valid = 4'b0000;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk("ar_first", 4'b1111, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 0, 4'b0000, 1'b0, 0));
    apply(mk("ar_resp",  4'b0000, 1'b0, 1'b1, 4'b1111, 32'h0000_00B0, 1'b0, -1, 4'b0001, 1'b1, 1));

    check("end", "sb_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snitch_shared_acc_arbiter.md
Name: snitch_shared_acc_arbiter

Overview:
Shares one offloaded accelerator (the shared MUL/DIV unit fed by instructions matching shared_offload) among NrCores Snitch core request ports.
- Arbitrates acc_req_t requests round-robin onto a single downstream port.
- Records the issuing core index in an in-order tracking FIFO.
- Routes each acc_resp_t back to the core that issued it.
- Sits between the core accelerator interfaces and the shared unit inside a tile.

Parameters:
NrCores, 4, number of requesting cores (>=2).
MaxOutstanding, 4, maximum accepted-but-unanswered downstream requests (>=1, power of two not required).
IdxWidth, idx_width(NrCores), width of core index (derived, do not override).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
core_req_i  in  NrCores x acc_req_t  per-core request payload
core_req_valid_i  in  NrCores  per-core request valid
core_req_ready_o  out  NrCores  per-core request ready
core_resp_o  out  NrCores x acc_resp_t  per-core response payload (all copies equal downstream payload)
core_resp_valid_o  out  NrCores  per-core response valid
core_resp_ready_i  in  NrCores  per-core response ready
acc_req_o  out  acc_req_t  request to shared unit
acc_req_valid_o  out  1  downstream request valid
acc_req_ready_i  in  1  downstream request ready
acc_resp_i  in  acc_resp_t  response from shared unit (in request order)
acc_resp_valid_i  in  1  downstream response valid
acc_resp_ready_o  out  1  downstream response ready
outstanding_o  out  idx_width(MaxOutstanding+1)  current tracking FIFO occupancy
busy_o  out  1  outstanding_o != 0 or acc_req_valid_o

Behaviour:
- Reset: all valid/ready outputs 0, outstanding_o 0, busy_o 0, RR pointer 0, lock cleared, FIFO empty. Reset mid-transaction discards all in-flight state; the shared unit is reset in the same domain.
- Handshake: valid/ready, transfer on the cycle both are high. Valid must not depend combinationally on ready in the same direction.
- Arbitration: eligible = core_req_valid_i & ~full.
  - When unlocked, grant the first eligible index at or after the RR pointer, wrapping NrCores-1 -> 0.
  - acc_req_o = granted payload; acc_req_valid_o = 1; core_req_ready_o[g] = acc_req_ready_i; all other ready bits 0.
- Lock: if acc_req_valid_o=1 and acc_req_ready_i=0, register the grant index and lock. While locked, the same core stays selected regardless of other requests. Cores must hold valid and payload stable until the handshake.
- On downstream request handshake:
  - RR pointer <= (g+1) mod NrCores; lock clears.
  - g is pushed into the tracking FIFO.
  - Zero-cycle pass-through: a request presented with ready high transfers in the same cycle.
- Full: occupancy == MaxOutstanding blocks new grants (acc_req_valid_o=0) even if a pop occurs the same cycle. A locked grant never exists while full, because the lock only forms on a valid issue.
- Response routing: head = FIFO head index.
  - core_resp_valid_o[head] = acc_resp_valid_i & ~empty; other bits 0.
  - acc_resp_ready_o = core_resp_ready_i[head] & ~empty.
  - Pop on downstream response handshake.
- Simultaneous push and pop: occupancy unchanged, both take effect.
- Response while empty: acc_resp_ready_o=0, no core sees valid. A simulation assertion flags a protocol error.
- The id field is passed through untouched in both directions; the arbiter does not interpret it.
- Latency: request 0 cycles combinational; response 0 cycles combinational. There are no pipeline registers on the data paths.
- Assertions: payload stability while locked; FIFO never overflows/underflows; at most one core_req_ready_o bit set.

Test Plan:
- Reset then single request: core 2 valid, acc_req_ready_i=1 -> same-cycle transfer, outstanding_o=1. Response data 32'hDEAD_BEEF -> only core_resp_valid_o[2] high, outstanding_o=0.
- Round-robin fairness: all 4 cores valid continuously, ready always 1 -> grant order 0,1,2,3,0,1 over 6 cycles.
- Backpressure lock: cores 1 and 3 valid, acc_req_ready_i=0 for 3 cycles -> core 1 stays selected and payload stable. Ready rises -> core 1 transfers, next grant is core 3.
- Full: MaxOutstanding=4, issue 4 requests without responses -> acc_req_valid_o=0 with requests pending. One response plus a new request in the same cycle -> request not granted until the next cycle.
- Out-of-turn response stall: FIFO order {0,2}, core 0 resp_ready=0 for 2 cycles -> acc_resp_ready_o=0 and core 2 sees no valid. Releasing core 0 delivers to core 0, then core 2.
- Async reset asserted with 3 outstanding -> all outputs 0 immediately, outstanding_o=0. After release, the first grant goes to core 0.
